// File: rtl/vm_pkg.sv
// Shared definitions for the vending datapath: coin values, price, credit width
// and the accumulator state encoding.
package vm_pkg;

    localparam int TOTAL_W = 6;

    localparam logic [TOTAL_W-1:0] NICKEL_VAL  = 6'd5;
    localparam logic [TOTAL_W-1:0] DIME_VAL    = 6'd10;
    localparam logic [TOTAL_W-1:0] QUARTER_VAL = 6'd25;
    localparam logic [TOTAL_W-1:0] PRICE       = 6'd20;
    localparam logic [TOTAL_W-1:0] MAX_TOTAL   = 6'd40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2
    } acc_state_t;

    // Credit of a strobe vector {quarter, dime, nickel}; zero unless exactly one is set.
    function automatic logic [TOTAL_W-1:0] coin_value(input logic [2:0] coins);
        logic [TOTAL_W-1:0] val;
        case (coins)
            3'b001:  val = NICKEL_VAL;
            3'b010:  val = DIME_VAL;
            3'b100:  val = QUARTER_VAL;
            default: val = 6'd0;
        endcase
        return val;
    endfunction

    function automatic logic coin_legal(input logic [2:0] coins);
        logic ok;
        case (coins)
            3'b001, 3'b010, 3'b100: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin-side and comparator-side signals of the accumulator; the slave modport
// is the accumulator's view.
interface coin_accumulator_if;
    import vm_pkg::*;

    logic               nickel_i;
    logic               dime_i;
    logic               quarter_i;
    logic               valid_i;
    logic [TOTAL_W-1:0] total_o;
    logic               vend_o;
    logic               reject_o;
    logic               refund_o;
    logic [TOTAL_W-1:0] refund_amt_o;

    modport slave (
        input  nickel_i, dime_i, quarter_i, valid_i,
        output total_o, vend_o, reject_o, refund_o, refund_amt_o
    );

    modport master (
        output nickel_i, dime_i, quarter_i, valid_i,
        input  total_o, vend_o, reject_o, refund_o, refund_amt_o
    );

endinterface

// File: rtl/coin_accumulator_chk.sv
// Invariants of the accumulator: credit never exceeds the largest reachable sum,
// the adder never carries, and a vend always carries at least the price.
module coin_accumulator_chk
    import vm_pkg::*;
(
    input logic               clk_i,
    input logic               rst_i,
    input logic [TOTAL_W-1:0] total_i,
    input logic               carry_i,
    input logic               vend_i,
    input logic               refund_i
);

    a_total_max: assert property (@(posedge clk_i) disable iff (rst_i)
        total_i <= MAX_TOTAL);

    a_no_carry: assert property (@(posedge clk_i) disable iff (rst_i)
        !carry_i);

    a_vend_price: assert property (@(posedge clk_i) disable iff (rst_i)
        vend_i |-> (total_i >= PRICE));

    a_vend_refund_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(vend_i && refund_i));

endmodule

// File: rtl/coin_accumulator_idle_timer.sv
// Coin-inactivity counter: clears on clr_i, counts on en_i and saturates at the
// last cycle, where expired_o is raised.
module idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then increment until the last cycle.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/coin_accumulator.sv
// Credit accumulator in front of the price comparator: sums coins, vends when the
// comparator reports enough credit, refunds after inactivity, rejects bad coins.
module coin_accumulator
    import vm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    coin_accumulator_if.slave bus
);

    acc_state_t         state_q, state_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               vend_q, vend_d;
    logic               reject_q, reject_d;
    logic               refund_q, refund_d;
    logic [TOTAL_W-1:0] refund_amt_q, refund_amt_d;

    logic [2:0]         coins_s;
    logic               coin_any_s;
    logic               coin_ok_s;
    logic [TOTAL_W-1:0] coin_val_s;
    logic [TOTAL_W:0]   sum_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic               expired_s;

    assign coins_s    = {bus.quarter_i, bus.dime_i, bus.nickel_i};
    assign coin_any_s = |coins_s;
    assign coin_ok_s  = coin_legal(coins_s);
    assign coin_val_s = coin_value(coins_s);
    assign sum_s      = {1'b0, total_q} + {1'b0, coin_val_s};

    idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (timer_clr_s),
        .en_i      (timer_en_s),
        .expired_o (expired_s)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        vend_d       = 1'b0;
        reject_d     = 1'b0;
        refund_d     = 1'b0;
        refund_amt_d = '0;
        timer_clr_s  = 1'b1;
        timer_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_ok_s) begin
                    total_d = sum_s[TOTAL_W-1:0];
                    state_d = COLLECT;
                end else begin
                    total_d  = '0;
                    reject_d = coin_any_s;
                end
            end
            COLLECT: begin
                if (bus.valid_i) begin
                    // Credit is frozen until the vend completes; late coins go back.
                    state_d  = VEND;
                    vend_d   = 1'b1;
                    reject_d = coin_any_s;
                end else if (coin_ok_s) begin
                    total_d = sum_s[TOTAL_W-1:0];
                end else begin
                    reject_d    = coin_any_s;
                    timer_clr_s = 1'b0;
                    timer_en_s  = 1'b1;
                    if (expired_s) begin
                        refund_d     = 1'b1;
                        refund_amt_d = total_q;
                        total_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        refund_d = 1'b0;
                    end
                end
            end
            VEND: begin
                reject_d = coin_any_s;
                total_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                total_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            total_q      <= '0;
            vend_q       <= 1'b0;
            reject_q     <= 1'b0;
            refund_q     <= 1'b0;
            refund_amt_q <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            vend_q       <= vend_d;
            reject_q     <= reject_d;
            refund_q     <= refund_d;
            refund_amt_q <= refund_amt_d;
        end
    end

    assign bus.total_o      = total_q;
    assign bus.vend_o       = vend_q;
    assign bus.reject_o     = reject_q;
    assign bus.refund_o     = refund_q;
    assign bus.refund_amt_o = refund_amt_q;

    coin_accumulator_chk u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .total_i  (total_q),
        .carry_i  (sum_s[TOTAL_W]),
        .vend_i   (vend_q),
        .refund_i (refund_q)
    );

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with a short timeout and a behavioural
// price comparator (valid when credit >= 20).
module tb_coin_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   pulses;

    always #5 clk = ~clk;

    coin_accumulator_if bus ();

    assign bus.valid_i = (bus.total_o >= 6'd20);

    coin_accumulator #(
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present one coin vector for one rising edge, then look #1 after that edge.
    task automatic step(input logic n, input logic d, input logic q);
        bus.nickel_i  = n;
        bus.dime_i    = d;
        bus.quarter_i = q;
        @(posedge clk);
        #1;
        bus.nickel_i  = 1'b0;
        bus.dime_i    = 1'b0;
        bus.quarter_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_total"},  32'(bus.total_o),      32'd0);
        check({tag, "_vend"},   32'(bus.vend_o),       32'd0);
        check({tag, "_reject"}, 32'(bus.reject_o),     32'd0);
        check({tag, "_refund"}, 32'(bus.refund_o),     32'd0);
        check({tag, "_amt"},    32'(bus.refund_amt_o), 32'd0);
    endtask

    initial begin
        bus.nickel_i  = 1'b0;
        bus.dime_i    = 1'b0;
        bus.quarter_i = 1'b0;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_all_zero("reset");

        // dime + dime -> vend at 20
        step(1'b0, 1'b1, 1'b0); check("dd_t10", 32'(bus.total_o), 32'd10);
        step(1'b0, 1'b1, 1'b0); check("dd_t20", 32'(bus.total_o), 32'd20);
        check("dd_novend", 32'(bus.vend_o), 32'd0);
        step(1'b0, 1'b0, 1'b0); check("dd_vend", 32'(bus.vend_o), 32'd1);
        check("dd_hold", 32'(bus.total_o), 32'd20);
        step(1'b0, 1'b0, 1'b0); check("dd_vend_off", 32'(bus.vend_o), 32'd0);
        check("dd_clear", 32'(bus.total_o), 32'd0);

        // nickel x3 + quarter -> 40
        step(1'b1, 1'b0, 1'b0); check("nq_t5",  32'(bus.total_o), 32'd5);
        step(1'b1, 1'b0, 1'b0); check("nq_t10", 32'(bus.total_o), 32'd10);
        step(1'b1, 1'b0, 1'b0); check("nq_t15", 32'(bus.total_o), 32'd15);
        step(1'b0, 1'b0, 1'b1); check("nq_t40", 32'(bus.total_o), 32'd40);
        step(1'b0, 1'b0, 1'b0); check("nq_vend", 32'(bus.vend_o), 32'd1);
        check("nq_hold", 32'(bus.total_o), 32'd40);
        step(1'b0, 1'b0, 1'b0); check("nq_vend_off", 32'(bus.vend_o), 32'd0);
        check("nq_clear", 32'(bus.total_o), 32'd0);

        // nickel+dime together in IDLE
        step(1'b1, 1'b1, 1'b0); check("multi_rej", 32'(bus.reject_o), 32'd1);
        check("multi_t0", 32'(bus.total_o), 32'd0);
        step(1'b0, 1'b0, 1'b0); check("multi_rej_off", 32'(bus.reject_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(bus.refund_o);
        end
        check("multi_idle_norefund", 32'(pulses), 32'd0);

        // late coins during valid and vend cycles
        step(1'b1, 1'b0, 1'b0); check("late_t5",  32'(bus.total_o), 32'd5);
        step(1'b0, 1'b1, 1'b0); check("late_t15", 32'(bus.total_o), 32'd15);
        step(1'b1, 1'b0, 1'b0); check("late_t20", 32'(bus.total_o), 32'd20);
        step(1'b0, 1'b1, 1'b0); check("late_rej1", 32'(bus.reject_o), 32'd1);
        check("late_vend", 32'(bus.vend_o), 32'd1);
        check("late_hold", 32'(bus.total_o), 32'd20);
        step(1'b1, 1'b0, 1'b0); check("late_rej2", 32'(bus.reject_o), 32'd1);
        check("late_vend_off", 32'(bus.vend_o), 32'd0);
        check("late_clear", 32'(bus.total_o), 32'd0);
        step(1'b0, 1'b0, 1'b0); check("late_rej_off", 32'(bus.reject_o), 32'd0);
        check("late_vend_once", 32'(bus.vend_o), 32'd0);

        // timeout refund of a nickel
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("to_pre", 32'(bus.refund_o), 32'd0);
        check("to_pre_t", 32'(bus.total_o), 32'd5);
        step(1'b0, 1'b0, 1'b0); check("to_refund", 32'(bus.refund_o), 32'd1);
        check("to_amt", 32'(bus.refund_amt_o), 32'd5);
        check("to_t0", 32'(bus.total_o), 32'd0);
        step(1'b0, 1'b0, 1'b0); check("to_refund_off", 32'(bus.refund_o), 32'd0);
        check("to_amt_off", 32'(bus.refund_amt_o), 32'd0);

        // dime on the expiry cycle is accepted, then a multi-coin on the next expiry
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); check("tod_norefund", 32'(bus.refund_o), 32'd0);
        check("tod_t15", 32'(bus.total_o), 32'd15);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("tom_pre", 32'(bus.refund_o), 32'd0);
        step(1'b1, 1'b1, 1'b0); check("tom_rej", 32'(bus.reject_o), 32'd1);
        check("tom_refund", 32'(bus.refund_o), 32'd1);
        check("tom_amt", 32'(bus.refund_amt_o), 32'd15);
        check("tom_t0", 32'(bus.total_o), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // reset mid-sale at 15
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); check("rst_t15", 32'(bus.total_o), 32'd15);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_all_zero("rst_mid");
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(bus.refund_o) + int'(bus.vend_o);
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
